// File: rtl/wb_regdump_ctrl.sv
// Register-file dump sequencer beside the WB stage: freezes the pipeline,
// walks read port 1 over every register and streams the words over valid/ready.
module wb_regdump_ctrl #(
    parameter int unsigned NB_DATA = 32,
    parameter int unsigned NB_REG  = 5
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_wb_reg_write,
    input  logic [NB_REG-1:0]  i_wb_selected_reg,
    input  logic [NB_DATA-1:0] i_wb_selected_data,
    input  logic               i_wb_hlt,
    input  logic               i_dump_req,
    input  logic [NB_DATA-1:0] i_rf_rd_data,
    input  logic               i_dump_ready,
    output logic               o_rf_rd_sel,
    output logic [NB_REG-1:0]  o_rf_rd_addr,
    output logic               o_dump_valid,
    output logic [NB_DATA-1:0] o_dump_data,
    output logic [NB_REG-1:0]  o_dump_addr,
    output logic               o_dump_last,
    output logic               o_pipe_stall,
    output logic               o_halted,
    output logic               o_done
);

    localparam logic [NB_REG-1:0] LAST_REG = {NB_REG{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_READ,
        ST_HOLD,
        ST_DONE
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [NB_REG-1:0]    r_cnt;
    logic [NB_REG-1:0]    w_cnt_nxt;
    logic [NB_DATA-1:0]   r_data;
    logic [NB_DATA-1:0]   w_data_nxt;
    logic                 r_halted;
    logic                 w_halted_any;
    logic                 w_fwd_hit;

    logic                 r_rd_sel;
    logic                 r_valid;
    logic                 r_last;
    logic                 r_stall;
    logic                 r_done;

    assign w_halted_any = r_halted | i_wb_hlt;
    // Register 0 is hard-wired, so a WB write to it is never forwarded.
    assign w_fwd_hit    = i_wb_reg_write && (i_wb_selected_reg == r_cnt) && (r_cnt != '0);

    // Next-state, counter and capture logic
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_data_nxt  = r_data;
        case (r_state)
            ST_IDLE: begin
                if (i_wb_hlt || i_dump_req) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                w_cnt_nxt   = '0;
                w_state_nxt = ST_READ;
            end
            ST_READ: begin
                w_data_nxt  = w_fwd_hit ? i_wb_selected_data : i_rf_rd_data;
                w_state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (i_dump_ready) begin
                    if (r_cnt == LAST_REG) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_cnt_nxt   = r_cnt + NB_REG'(1);
                        w_state_nxt = ST_READ;
                    end
                end
            end
            ST_DONE: begin
                // A halted core stays parked; a step dump waits for the request to drop.
                if (!w_halted_any && !i_dump_req) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath and output flags, decoded from the next state so they line up with it
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_cnt    <= '0;
            r_data   <= '0;
            r_halted <= 1'b0;
            r_rd_sel <= 1'b0;
            r_valid  <= 1'b0;
            r_last   <= 1'b0;
            r_stall  <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_data   <= w_data_nxt;
            r_halted <= w_halted_any;
            r_rd_sel <= (w_state_nxt == ST_READ);
            r_valid  <= (w_state_nxt == ST_HOLD);
            r_last   <= (w_state_nxt == ST_HOLD) && (w_cnt_nxt == LAST_REG);
            r_stall  <= (w_state_nxt != ST_IDLE);
            r_done   <= (w_state_nxt == ST_DONE);
        end
    end

    assign o_rf_rd_sel  = r_rd_sel;
    assign o_rf_rd_addr = r_cnt;
    assign o_dump_valid = r_valid;
    assign o_dump_data  = r_data;
    assign o_dump_addr  = r_cnt;
    assign o_dump_last  = r_last;
    assign o_pipe_stall = r_stall;
    assign o_halted     = r_halted;
    assign o_done       = r_done;

endmodule

// File: doc/wb_regdump_ctrl.md
Name: wb_regdump_ctrl

Overview:
- Sequences a register-file dump to the debug unit whenever a halt reaches write-back, or when the debug unit requests one (step mode).
- Sits beside the WB stage and register bank.
- Owns register-bank read port 1 while dumping, and freezes the pipeline for the duration.
- Streams the 32 registers out one at a time over a valid/ready handshake. A same-cycle WB write to the register being read is forwarded (write-through).

Parameters:
NB_DATA, 32, register data width
NB_REG, 5, register address width; dump covers 2**NB_REG registers

Ports:
i_clock  in  1  system clock, rising edge
i_reset  in  1  asynchronous, active-high reset
i_wb_reg_write  in  1  WB stage write enable
i_wb_selected_reg  in  NB_REG  WB destination register
i_wb_selected_data  in  NB_DATA  WB write data
i_wb_hlt  in  1  halt instruction present in WB this cycle
i_dump_req  in  1  debug dump request (level)
i_rf_rd_data  in  NB_DATA  register-bank read port 1 data (combinational read)
i_dump_ready  in  1  debug unit accepts the current word
o_rf_rd_sel  out  1  1 = controller drives read port 1 address
o_rf_rd_addr  out  NB_REG  read port 1 address while o_rf_rd_sel=1
o_dump_valid  out  1  o_dump_data/o_dump_addr valid
o_dump_data  out  NB_DATA  register value
o_dump_addr  out  NB_REG  register index of o_dump_data
o_dump_last  out  1  high with o_dump_valid on the final register
o_pipe_stall  out  1  freeze IF..MEM pipeline registers
o_halted  out  1  sticky: halt has committed
o_done  out  1  dump finished

Behaviour:
- Reset (asynchronous, active-high): state IDLE, address counter 0, data register 0, halted flag 0. All outputs 0.
- States: IDLE, DRAIN, READ, HOLD, DONE.
- IDLE:
  - i_wb_hlt=1 -> set halted, go to DRAIN.
  - else i_dump_req=1 -> go to DRAIN.
  - Both asserted together: treated as halt.
- DRAIN: one cycle so the in-flight WB write commits. o_pipe_stall=1. Address counter cleared to 0. Next state READ.
- READ:
  - o_rf_rd_sel=1, o_rf_rd_addr=counter.
  - Capture into the data register: i_wb_selected_data if i_wb_reg_write=1, i_wb_selected_reg=counter and counter!=0; else i_rf_rd_data.
  - Next state HOLD.
- HOLD:
  - o_dump_valid=1, o_dump_data=data register, o_dump_addr=counter.
  - o_dump_last=1 when counter=2**NB_REG-1.
  - Outputs hold stable until i_dump_ready=1.
  - On valid&&ready: last -> DONE; else counter+1 -> READ.
  - Throughput: one word per 2 cycles minimum.
- DONE:
  - o_done=1.
  - If halted=1: stay in DONE until reset.
  - Else: return to IDLE when i_dump_req=0. A held request does not retrigger; it must drop before a new dump.
- o_pipe_stall=1 in DRAIN, READ, HOLD, DONE; 0 in IDLE. o_rf_rd_sel=1 only in READ.
- i_wb_hlt sampled in any non-reset state sets halted; e.g. a halt arriving during DRAIN of a requested dump makes DONE terminal.
- o_halted = halted flag, registered.
- Counter wraps naturally but never increments past the last register (DONE is entered first).
- i_dump_ready while o_dump_valid=0 is ignored.
- Reset mid-dump: immediate return to IDLE and counter 0; partial dump abandoned with no o_dump_last.

Test Plan:
- Halt path: preload reg k with value 0x100+k, pulse i_wb_hlt 1 cycle, hold i_dump_ready=1 -> 32 words, addr 0..31, data 0x100+addr, o_dump_last only on addr 31; o_done=1 and o_halted=1 persist; i_dump_req toggles have no effect.
- Backpressure: during a dump, drop i_dump_ready for 5 cycles at addr 7 -> addr 7 and its data held stable, no word skipped or duplicated; dump resumes at addr 8 once ready returns.
- Write-through: in the READ cycle for addr 3, drive WB write reg 3 = 0xDEADBEEF -> word 3 = 0xDEADBEEF. Same WB write to reg 0 during the addr-0 READ -> word 0 = i_rf_rd_data.
- Step-mode request: raise i_dump_req in IDLE -> DRAIN, 32 words, DONE; hold request 10 cycles -> stays DONE, no retrigger; drop request -> IDLE, o_pipe_stall=0 next cycle.
- Simultaneous and mid-dump events: i_wb_hlt and i_dump_req asserted together in IDLE -> o_halted=1, DONE terminal. Separately, assert i_reset in HOLD at addr 12 -> all outputs 0 immediately; a new request restarts at addr 0.
